// File: rtl/fp_align_pipe.sv
// Two-stage operand aligner: S1 orders the pair by magnitude,
// S2 right-aligns the smaller mantissa and collects the sticky bit.
module fp_align_pipe #(
   parameter int MAN_W = 10,
   parameter int EXP_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MAN_W-1:0] in_man1,
   input  logic [MAN_W-1:0] in_man2,
   input  logic             in_sgn1,
   input  logic             in_sgn2,
   input  logic [EXP_W-1:0] in_exp1,
   input  logic [EXP_W-1:0] in_exp2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MAN_W-1:0] out_man_big,
   output logic             out_sgn_big,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_man_small,
   output logic             out_sgn_small,
   output logic             out_sticky,
   output logic             out_swapped,
   output logic [EXP_W-1:0] out_diff,
   output logic [CNT_W-1:0] txn_cnt
);

   logic             s1_valid;
   logic [MAN_W-1:0] s1_man_big;
   logic [MAN_W-1:0] s1_man_small;
   logic [EXP_W-1:0] s1_exp;
   logic [EXP_W-1:0] s1_diff;
   logic             s1_sgn_big;
   logic             s1_sgn_small;
   logic             s1_swapped;

   logic             s2_adv;
   logic             op1_big;
   logic [EXP_W-1:0] diff_c;
   logic [MAN_W-1:0] shifted;
   logic             sticky;

   assign s2_adv   = !out_valid | out_ready;
   assign in_ready = !s1_valid | s2_adv;

   always_comb begin
      op1_big = (in_exp1 > in_exp2) ||
                ((in_exp1 == in_exp2) && (in_man1 >= in_man2));
      diff_c  = op1_big ? (in_exp1 - in_exp2) : (in_exp2 - in_exp1);
   end

   // shifting by >= MAN_W clears the mantissa; every bit lands in sticky
   always_comb begin
      shifted = s1_man_small >> s1_diff;
      sticky  = 1'b0;
      for (int i = 0; i < MAN_W; i++) begin
         if (i < int'(s1_diff))
            sticky = sticky | s1_man_small[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_man_big    <= '0;
         s1_man_small  <= '0;
         s1_exp        <= '0;
         s1_diff       <= '0;
         s1_sgn_big    <= 1'b0;
         s1_sgn_small  <= 1'b0;
         s1_swapped    <= 1'b0;
         out_valid     <= 1'b0;
         out_man_big   <= '0;
         out_sgn_big   <= 1'b0;
         out_exp       <= '0;
         out_man_small <= '0;
         out_sgn_small <= 1'b0;
         out_sticky    <= 1'b0;
         out_swapped   <= 1'b0;
         out_diff      <= '0;
         txn_cnt       <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_man_big   <= op1_big ? in_man1 : in_man2;
               s1_man_small <= op1_big ? in_man2 : in_man1;
               s1_exp       <= op1_big ? in_exp1 : in_exp2;
               s1_sgn_big   <= op1_big ? in_sgn1 : in_sgn2;
               s1_sgn_small <= op1_big ? in_sgn2 : in_sgn1;
               s1_diff      <= diff_c;
               s1_swapped   <= !op1_big;
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_man_big   <= s1_man_big;
               out_sgn_big   <= s1_sgn_big;
               out_exp       <= s1_exp;
               out_man_small <= shifted;
               out_sgn_small <= s1_sgn_small;
               out_sticky    <= sticky;
               out_swapped   <= s1_swapped;
               out_diff      <= s1_diff;
            end
         end
         if (out_valid && out_ready)
            txn_cnt <= txn_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Randomized bench for fp_align_pipe against a queue-based
// arithmetic reference of the alignment rules.
module tb_fp_align_pipe;

   localparam int MW = 10;
   localparam int EW = 5;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [MW-1:0] in_man1, in_man2;
   logic          in_sgn1, in_sgn2;
   logic [EW-1:0] in_exp1, in_exp2;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] out_man_big, out_man_small;
   logic          out_sgn_big, out_sgn_small;
   logic [EW-1:0] out_exp, out_diff;
   logic          out_sticky, out_swapped;
   logic [CW-1:0] txn_cnt;

   fp_align_pipe #(.MAN_W(MW), .EXP_W(EW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_man1(in_man1), .in_man2(in_man2),
      .in_sgn1(in_sgn1), .in_sgn2(in_sgn2),
      .in_exp1(in_exp1), .in_exp2(in_exp2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_man_big(out_man_big), .out_sgn_big(out_sgn_big),
      .out_exp(out_exp), .out_man_small(out_man_small),
      .out_sgn_small(out_sgn_small), .out_sticky(out_sticky),
      .out_swapped(out_swapped), .out_diff(out_diff),
      .txn_cnt(txn_cnt)
   );

   always #5 clk = ~clk;

   typedef logic [33:0] bndl_t;

   int            n_cmp = 0;
   int            n_bad = 0;
   bndl_t         q[$];
   logic [CW-1:0] exp_cnt;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bndl_t dut_bndl();
      return {out_man_big, out_sgn_big, out_exp, out_man_small,
              out_sgn_small, out_sticky, out_swapped, out_diff};
   endfunction

   function automatic bndl_t model(int m1, int e1, bit s1,
                                   int m2, int e2, bit s2);
      bit sw;
      int bm, be, sm, se, d, ms;
      bit bs, ss, st;
      sw = !(e1 > e2 || (e1 == e2 && m1 >= m2));
      bm = sw ? m2 : m1;  be = sw ? e2 : e1;  bs = sw ? s2 : s1;
      sm = sw ? m1 : m2;  se = sw ? e1 : e2;  ss = sw ? s1 : s2;
      d  = be - se;
      if (d < MW) begin
         ms = sm / (2 ** d);
         st = (sm % (2 ** d)) != 0;
      end else begin
         ms = 0;
         st = sm != 0;
      end
      return {MW'(bm), bs, EW'(be), MW'(ms), ss, st, sw, EW'(d)};
   endfunction

   task automatic idle_inputs();
      in_valid = 0;
      in_man1 = '0; in_man2 = '0; in_sgn1 = 0; in_sgn2 = 0;
      in_exp1 = '0; in_exp2 = '0;
   endtask

   // single pair through an empty pipe; checks the 2-cycle latency
   task automatic send_one(input int m1, input int e1, input bit s1,
                           input int m2, input int e2, input bit s2);
      @(negedge clk);
      in_valid = 1; out_ready = 1;
      in_man1 = MW'(m1); in_exp1 = EW'(e1); in_sgn1 = s1;
      in_man2 = MW'(m2); in_exp2 = EW'(e2); in_sgn2 = s2;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      chk("lat1_ov", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat2_ov", out_valid, 1);
      chk("dir_bndl", dut_bndl(), model(m1, e1, s1, m2, e2, s2));
      @(posedge clk);
      exp_cnt++;
      @(negedge clk);
      chk("dir_cnt", txn_cnt, exp_cnt);
   endtask

   initial begin
      bndl_t snap, held;
      bit    hold, acc, take;
      int    m1, m2, e1, e2;
      bit    s1, s2;

      rst = 1; out_ready = 0; idle_inputs();
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ov", out_valid, 0);
      chk("rst_cnt", txn_cnt, 0);
      chk("rst_bndl", dut_bndl(), 0);
      rst = 0;
      #1;
      chk("rst_ir", in_ready, 1);

      send_one(0, 17, 0, 32, 11, 1);
      chk("r40_sw", out_swapped, 0);
      chk("r40_exp", out_exp, 17);
      chk("r40_diff", out_diff, 6);
      chk("r40_ms", out_man_small, 0);
      chk("r40_st", out_sticky, 1);
      send_one(484, 9, 1, 391, 11, 0);
      chk("r41_sw", out_swapped, 1);
      chk("r41_mb", out_man_big, 391);
      chk("r41_ms", out_man_small, 121);
      chk("r41_st", out_sticky, 0);
      send_one(14, 11, 0, 3, 11, 1);
      chk("r42a_sw", out_swapped, 0);
      chk("r42a_ms", out_man_small, 3);
      send_one(3, 11, 0, 14, 11, 0);
      chk("r42b_sw", out_swapped, 1);
      chk("r42b_mb", out_man_big, 14);
      send_one(897, 29, 0, 141, 5, 1);
      chk("r43_diff", out_diff, 24);
      chk("r43_ms", out_man_small, 0);
      chk("r43_st", out_sticky, 1);
      send_one(77, 3, 1, 77, 3, 0);
      chk("tie_sw", out_swapped, 0);
      chk("tie_st", out_sticky, 0);

      // random stream with back-pressure; long enough to wrap txn_cnt
      hold = 0; held = '0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         m1 = $urandom_range(0, 2 ** MW - 1);
         e1 = $urandom_range(0, 2 ** EW - 1);
         s1 = 1'($urandom);
         s2 = 1'($urandom);
         m2 = ($urandom % 8 == 0) ? m1 : $urandom_range(0, 2 ** MW - 1);
         e2 = ($urandom % 4 == 0) ? e1 : $urandom_range(0, 2 ** EW - 1);
         in_valid = ($urandom % 4) != 0;
         in_man1 = MW'(m1); in_exp1 = EW'(e1); in_sgn1 = s1;
         in_man2 = MW'(m2); in_exp2 = EW'(e2); in_sgn2 = s2;
         out_ready = (cyc < 300) ? 1'b1 : (($urandom % 3) != 0);
         #1;
         chk("ir", in_ready, (q.size() < 2) || out_ready);
         chk("cnt", txn_cnt, exp_cnt);
         if (out_valid && q.size() == 0)
            chk("ov_empty", 1, 0);
         snap = dut_bndl();
         if (hold) begin
            chk("hold_ov", out_valid, 1);
            chk("hold_bndl", snap, held);
         end
         acc  = in_valid && in_ready;
         take = out_valid && out_ready;
         @(posedge clk);
         if (take) begin
            if (q.size() == 0) chk("pop_empty", 1, 0);
            else chk("res", snap, q.pop_front());
            exp_cnt++;
         end
         if (acc) q.push_back(model(m1, e1, s1, m2, e2, s2));
         hold = out_valid && !out_ready;
         held = snap;
      end

      // drain then load two pairs and reset them away
      @(negedge clk);
      in_valid = 0; out_ready = 1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      out_ready = 0; in_valid = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      in_valid = 0; rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      q.delete();
      exp_cnt = '0;
      chk("mid_ov", out_valid, 0);
      chk("mid_cnt", txn_cnt, 0);
      chk("mid_ir", in_ready, 1);
      out_ready = 1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("stale_ov", out_valid, 0);
      end
      chk("end_cnt", txn_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
